// File: rtl/mem_resp_pkg.sv
// ---------------------------------------------------------------------------
// mem_resp_pkg
//   Shared definitions for the fixed-latency memory read responder:
//     DATA_W / BYTE_W / BYTES : word geometry (64-bit words, 8-bit bytes)
//     resp_t                  : one in-flight response record (valid + data)
//     reset_word()            : power-on contents of word a, where
//                               byte k = (8*a + k + 1) mod 256
// ---------------------------------------------------------------------------
package mem_resp_pkg;

    localparam int DATA_W = 64;
    localparam int BYTE_W = 8;
    localparam int BYTES  = DATA_W / BYTE_W;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
    } resp_t;

    function automatic logic [DATA_W-1:0] reset_word(input int unsigned addr);
        logic [DATA_W-1:0] w;
        w = '0;
        for (int k = 0; k < BYTES; k++) begin
            w[k*BYTE_W +: BYTE_W] = BYTE_W'((addr * BYTES + k + 1) % 256);
        end
        return w;
    endfunction

endpackage

// File: rtl/resp_pipe.sv
// ---------------------------------------------------------------------------
// resp_pipe
//   Fixed-latency delay line for read responses: LATENCY register stages of
//   (valid, data). A record loaded at a rising edge appears on 'response'
//   LATENCY-1 edges later, i.e. LATENCY cycles after the cycle in which the
//   read was presented and accepted.
//   Ports:
//     clk       : clock, rising edge
//     rst_n     : asynchronous active-low reset, empties every stage
//     accepted  : record entering the line this edge (valid=0 when idle)
//     response  : record leaving the line (last stage)
// ---------------------------------------------------------------------------
module resp_pipe
    import mem_resp_pkg::*;
#(
    parameter int LATENCY = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    input  resp_t accepted,
    output resp_t response
);

    resp_t stages [LATENCY];

    // NOTE: every flop here is written with <= so all stages shift on the
    // same edge; blocking assignments would collapse the line to one stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= accepted;
            for (int i = 1; i < LATENCY; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign response = stages[LATENCY-1];

endmodule

// File: rtl/mem_read_responder.sv
// ---------------------------------------------------------------------------
// mem_read_responder
//   Small word memory with a fixed-latency, pipelined read response path and
//   a bounded number of outstanding reads.
//   Ports:
//     clk           : clock, rising edge
//     rst_n         : asynchronous active-low reset; restores the power-on
//                     memory pattern and discards in-flight reads
//     address       : word address of the request
//     read / write  : request strobes (write wins when both are high)
//     writedata     : write data, byte k = bits 8k+7:8k
//     waitrequest   : request not accepted this cycle
//     readdata      : returned word, 0 when readdatavalid is low
//     readdatavalid : one-cycle response strobe, LATENCY cycles after accept
//     err           : sticky flag, set by a simultaneous read+write
// ---------------------------------------------------------------------------
module mem_read_responder
    import mem_resp_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int LATENCY     = 4,
    parameter int MAX_PENDING = 3,
    localparam int ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [DATA_W-1:0] writedata,
    output logic              waitrequest,
    output logic [DATA_W-1:0] readdata,
    output logic              readdatavalid,
    output logic              err
);

    localparam int PEND_W = $clog2(MAX_PENDING + 1);

    logic [DATA_W-1:0] words [DEPTH];
    logic [PEND_W-1:0] pending;
    resp_t             accepted;
    resp_t             response;
    logic              retire;
    logic              accept_read;
    logic              accept_write;
    logic              in_range;

    // Only matters when DEPTH is not a power of two.
    assign in_range = (32'(address) < 32'(DEPTH));

    // A response leaving the pipe this cycle frees a slot, so a full
    // counter does not stall when a retirement is under way.
    assign retire       = response.valid;
    assign waitrequest  = (pending == PEND_W'(MAX_PENDING)) && !retire;
    assign accept_write = write && !waitrequest;
    assign accept_read  = read && !write && !waitrequest;

    // The word is captured here at acceptance, so a later write to the same
    // address cannot alter data already travelling down the pipe.
    // NOTE: always_comb outputs get a default first so no path leaves them
    // unassigned, which would infer a latch.
    always_comb begin
        accepted = '0;
        if (accept_read) begin
            accepted.valid = 1'b1;
            accepted.data  = in_range ? words[address] : '0;
        end
    end

    resp_pipe #(
        .LATENCY (LATENCY)
    ) u_resp_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .accepted (accepted),
        .response (response)
    );

    // Idle pipe stages hold zero data, so readdata is 0 whenever
    // readdatavalid is low without any extra gating.
    assign readdata      = response.data;
    assign readdatavalid = response.valid;

    // NOTE: this storage is reset on purpose -- the power-on pattern is part
    // of its function, so it is built from flops rather than a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int a = 0; a < DEPTH; a++) begin
                words[a] <= reset_word(a);
            end
        end else if (accept_write && in_range) begin
            words[address] <= writedata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else if (accept_read && !retire) begin
            pending <= pending + 1'b1;
        end else if (!accept_read && retire) begin
            pending <= pending - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (read && write && !waitrequest) begin
            err <= 1'b1;
        end
    end

endmodule
